// File: rtl/regbag_rf.sv
// RV32I integer register file: MEM/WB write-back sink, two combinational decode
// read ports with optional same-cycle bypass, a registered debug port and a retired-write counter.
module regbag_rf #(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int BYPASS_EN = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regbag_w_en,
    input  logic [AW-1:0]    regbag_w_addr,
    input  logic [XLEN-1:0]  regbag_w_data,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [XLEN-1:0]  dbg_data,
    output logic [CNT_W-1:0] wr_count
);

    localparam int NREG = 1 << AW;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  dbg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wr_accept;

    // x0 writes are neither stored nor counted; reset suppresses both as well.
    assign wr_accept = !rst && regbag_w_en && (regbag_w_addr != '0);
    assign cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, wr_accept};

    // NOTE: the whole array is cleared by reset, so it is built from resettable
    // flops rather than a RAM macro; every entry must read 0 the cycle after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            dbg_q <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_accept) begin
                regs_q[regbag_w_addr] <= regbag_w_data;
            end
            // Samples the array before this edge's write lands: same-index write returns the old value.
            dbg_q <= (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if ((BYPASS_EN != 0) && wr_accept && (regbag_w_addr == rs1_addr)) begin
            rs1_data = regbag_w_data;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if ((BYPASS_EN != 0) && wr_accept && (regbag_w_addr == rs2_addr)) begin
            rs2_data = regbag_w_data;
        end
    end

    assign dbg_data = dbg_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_regbag_rf.sv
// Scoreboard bench for regbag_rf: bypassing, non-bypassing and 4-bit-counter
// instances share one directed stimulus stream; a negedge monitor drains expectations.
module tb_regbag_rf;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  rs1_addr, rs2_addr, dbg_addr;

    logic [31:0] rs1_a, rs2_a, dbg_a, cnt_a;
    logic [31:0] rs1_b, rs2_b, dbg_b, cnt_b;
    logic [31:0] rs1_c, rs2_c, dbg_c;
    logic [3:0]  cnt_c;

    always #5 clk = ~clk;

    regbag_rf #(.XLEN(32), .AW(5), .BYPASS_EN(1), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .regbag_w_en(w_en), .regbag_w_addr(w_addr),
        .regbag_w_data(w_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_a), .rs2_data(rs2_a), .dbg_addr(dbg_addr),
        .dbg_data(dbg_a), .wr_count(cnt_a)
    );

    regbag_rf #(.XLEN(32), .AW(5), .BYPASS_EN(0), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .regbag_w_en(w_en), .regbag_w_addr(w_addr),
        .regbag_w_data(w_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_b), .rs2_data(rs2_b), .dbg_addr(dbg_addr),
        .dbg_data(dbg_b), .wr_count(cnt_b)
    );

    regbag_rf #(.XLEN(32), .AW(5), .BYPASS_EN(1), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .regbag_w_en(w_en), .regbag_w_addr(w_addr),
        .regbag_w_data(w_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_c), .rs2_data(rs2_c), .dbg_addr(dbg_addr),
        .dbg_data(dbg_c), .wr_count(cnt_c)
    );

    typedef enum int {
        S_RS1_A, S_RS2_A, S_DBG_A, S_CNT_A,
        S_RS1_B, S_RS2_B, S_DBG_B, S_CNT_B,
        S_CNT_C
    } sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input sel_e sel, input logic [31:0] exp);
        sb.push_back('{name, sel, exp});
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.sel)
                S_RS1_A: act = rs1_a;
                S_RS2_A: act = rs2_a;
                S_DBG_A: act = dbg_a;
                S_CNT_A: act = cnt_a;
                S_RS1_B: act = rs1_b;
                S_RS2_B: act = rs2_b;
                S_DBG_B: act = dbg_b;
                S_CNT_B: act = cnt_b;
                S_CNT_C: act = {28'd0, cnt_c};
                default: act = 'x;
            endcase
            n_vec++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] da);
        rst = r; w_en = we; w_addr = wa; w_data = wd;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = da;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        step();
        step();

        // Reset discards everything, including a write presented during reset.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd5);
        step();
        drive(1'b1, 1'b1, 5'd7, 32'h00000077, 5'd7, 5'd5, 5'd5);
        check("rst_no_bypass_x7", S_RS1_A, 32'h0);
        check("pre_rst_x5",       S_RS2_A, 32'hDEADBEEF);
        check("dbg_old_x5",       S_DBG_A, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd5);
        check("rst_clear_x5",  S_RS1_A, 32'h0);
        check("rst_clear_x7",  S_RS2_A, 32'h0);
        check("rst_cnt_a",     S_CNT_A, 32'h0);
        check("rst_cnt_c",     S_CNT_C, 32'h0);
        check("rst_dbg",       S_DBG_A, 32'h0);
        check("rst_clear_x5b", S_RS1_B, 32'h0);
        step();

        // Basic write then read.
        drive(1'b0, 1'b1, 5'd10, 32'h12345678, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd0, 5'd0);
        check("basic_rd_a", S_RS1_A, 32'h12345678);
        check("basic_rd_b", S_RS1_B, 32'h12345678);
        check("basic_cnt_a", S_CNT_A, 32'd1);
        check("basic_cnt_c", S_CNT_C, 32'd1);
        step();

        // x0 stays zero and x0 writes are not counted.
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        check("x0_same_cyc_a", S_RS1_A, 32'h0);
        check("x0_same_cyc_b", S_RS1_B, 32'h0);
        check("x0_same_cyc_r2", S_RS2_A, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        check("x0_after",  S_RS1_A, 32'h0);
        check("x0_cnt",    S_CNT_A, 32'd1);
        check("x0_dbg",    S_DBG_A, 32'h0);
        step();

        // Same-cycle bypass on both ports.
        drive(1'b0, 1'b1, 5'd3, 32'h00000001, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3, 5'd3);
        check("byp_rs1_a",   S_RS1_A, 32'hAAAA5555);
        check("byp_rs2_a",   S_RS2_A, 32'hAAAA5555);
        check("nobyp_rs1_b", S_RS1_B, 32'h00000001);
        check("nobyp_rs2_b", S_RS2_B, 32'h00000001);
        check("byp_cnt",     S_CNT_A, 32'd2);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
        check("nobyp_next_b", S_RS1_B, 32'hAAAA5555);
        check("nobyp_next_r2", S_RS2_B, 32'hAAAA5555);
        check("byp_next_a",   S_RS1_A, 32'hAAAA5555);
        check("dbg_x3_one",   S_DBG_A, 32'h00000001);
        check("byp_cnt2",     S_CNT_B, 32'd3);
        step();

        // Debug port returns the old value when write and read share an edge.
        drive(1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 5'd0, 5'd0, 5'd3);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd3);
        check("dbg_old_a", S_DBG_A, 32'hAAAA5555);
        check("dbg_old_b", S_DBG_B, 32'hAAAA5555);
        step();
        check("dbg_new_a", S_DBG_A, 32'hCAFEF00D);
        check("dbg_cnt",   S_CNT_A, 32'd4);
        step();

        // Counter wrap on the 4-bit instance, with interleaved x0 writes.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        step();
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 5'(i + 1), 32'h1000 + 32'(i), 5'd3, 5'd0, 5'd0);
            if (i == 0) begin
                check("wrap_start_c", S_CNT_C, 32'd0);
                check("wrap_rst_x3",  S_RS1_B, 32'h0);
            end
            if (i == 16) begin
                check("wrap_16_c", S_CNT_C, 32'd0);
                check("wrap_16_a", S_CNT_A, 32'd16);
            end
            step();
            if (i < 5) begin
                drive(1'b0, 1'b1, 5'd0, 32'h00000BAD, 5'd0, 5'd0, 5'd0);
                step();
            end
        end
        drive(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd17, 5'd1, 5'd0);
        check("wrap_17_c",  S_CNT_C, 32'd1);
        check("wrap_17_a",  S_CNT_A, 32'd17);
        check("wrap_rd_x17", S_RS1_A, 32'h00001010);
        check("wrap_rd_x1",  S_RS2_A, 32'h00001000);
        check("byp_x31_a",   S_RS1_A, 32'h00001010);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd0, 5'd31);
        check("x31_rd_a", S_RS1_A, 32'hFFFFFFFF);
        check("x31_rd_b", S_RS1_B, 32'hFFFFFFFF);
        check("cnt_18_a", S_CNT_A, 32'd18);
        check("cnt_2_c",  S_CNT_C, 32'd2);
        step();
        check("dbg_x31", S_DBG_A, 32'hFFFFFFFF);
        step();
        step();

        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
            n_fail++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
